// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  video_timing_gen
//  Raster timing source: pixel coordinates, syncs, data enable and line/frame
//  start pulses, all registered and aligned to the same pixel position.
//  Revision: 1.0
// ============================================================================
module video_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FRONT  = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BACK   = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FRONT  = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BACK   = 20,
   parameter int SYNC_POL = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pix_en,
   output logic [15:0] o_x,
   output logic [15:0] o_y,
   output logic        o_h_sync,
   output logic        o_v_sync,
   output logic        o_de,
   output logic        o_frame_start,
   output logic        o_line_start
);

   localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [15:0] c_h_last   = 16'(c_h_total - 1);
   localparam logic [15:0] c_h_fp_beg = 16'(H_ACTIVE);
   localparam logic [15:0] c_h_sy_beg = 16'(H_ACTIVE + H_FRONT);
   localparam logic [15:0] c_h_bp_beg = 16'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [15:0] c_v_last   = 16'(c_v_total - 1);
   localparam logic [15:0] c_v_fp_beg = 16'(V_ACTIVE);
   localparam logic [15:0] c_v_sy_beg = 16'(V_ACTIVE + V_FRONT);
   localparam logic [15:0] c_v_bp_beg = 16'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic        c_pol      = (SYNC_POL != 0);

   generate
      if (H_SYNC < 1 || V_SYNC < 1 || c_h_total > 65535 || c_v_total > 65535) begin : g_bad_params
         $fatal(1, "video_timing_gen: sync widths must be >= 1 and totals <= 65535");
      end
   endgenerate

   typedef enum logic [1:0] {H_ACT = 2'd0, H_FP = 2'd1, H_SY = 2'd2, H_BP = 2'd3} h_state_t;
   typedef enum logic [1:0] {V_ACT = 2'd0, V_FP = 2'd1, V_SY = 2'd2, V_BP = 2'd3} v_state_t;

   // Zero-width porches collapse to equal boundaries, so that phase is skipped.
   function automatic h_state_t h_phase(input logic [15:0] x);
      if (x < c_h_fp_beg)      return H_ACT;
      else if (x < c_h_sy_beg) return H_FP;
      else if (x < c_h_bp_beg) return H_SY;
      else                     return H_BP;
   endfunction

   function automatic v_state_t v_phase(input logic [15:0] y);
      if (y < c_v_fp_beg)      return V_ACT;
      else if (y < c_v_sy_beg) return V_FP;
      else if (y < c_v_bp_beg) return V_SY;
      else                     return V_BP;
   endfunction

   h_state_t    r_h_state, w_h_state_nxt;
   v_state_t    r_v_state, w_v_state_nxt;
   logic [15:0] w_x_nxt, w_y_nxt;
   logic        w_h_wrap, w_v_wrap;

   always_comb begin
      w_x_nxt       = o_x;
      w_y_nxt       = o_y;
      w_h_wrap      = 1'b0;
      w_v_wrap      = 1'b0;
      w_h_state_nxt = r_h_state;
      w_v_state_nxt = r_v_state;
      if (i_pix_en) begin
         if (o_x == c_h_last) begin
            w_x_nxt  = 16'd0;
            w_h_wrap = 1'b1;
            if (o_y == c_v_last) begin
               w_y_nxt  = 16'd0;
               w_v_wrap = 1'b1;
            end else begin
               w_y_nxt = o_y + 16'd1;
            end
         end else begin
            w_x_nxt = o_x + 16'd1;
         end
         w_h_state_nxt = h_phase(w_x_nxt);
         // Vertical phase only moves at the line boundary.
         if (w_h_wrap) begin
            w_v_state_nxt = v_phase(w_y_nxt);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_x           <= 16'd0;
         o_y           <= 16'd0;
         r_h_state     <= H_ACT;
         r_v_state     <= V_ACT;
         o_h_sync      <= ~c_pol;
         o_v_sync      <= ~c_pol;
         o_de          <= 1'b1;
         o_frame_start <= 1'b0;
         o_line_start  <= 1'b0;
      end else begin
         o_x           <= w_x_nxt;
         o_y           <= w_y_nxt;
         r_h_state     <= w_h_state_nxt;
         r_v_state     <= w_v_state_nxt;
         o_h_sync      <= (w_h_state_nxt == H_SY) ? c_pol : ~c_pol;
         o_v_sync      <= (w_v_state_nxt == V_SY) ? c_pol : ~c_pol;
         o_de          <= (w_h_state_nxt == H_ACT) && (w_v_state_nxt == V_ACT);
         o_frame_start <= w_v_wrap;
         o_line_start  <= w_h_wrap;
      end
   end

endmodule
`default_nettype wire
